systolic_mult_ctrl: RTL and testbench
=====================================

# systolic_mult_ctrl

Sequencing controller for a W-cell bit-serial systolic multiplier array. It accepts an operand pair over a valid/ready handshake and drives the multiplicand onto the per-cell weight bits. It clears the array, streams the multiplier LSB-first into cell 0 with zero padding, and deserialises the 2W-bit product returned by cell 0. It is the only block that talks to the array, and it presents a word-level multiply interface to the surrounding datapath.

## Interface
- W, default 8: operand width and number of array cells; legal range 2..32.
- ARRAY_LAT, default 1: cycles from a bit entering cell 0 to the matching product bit on i_ARRAY_OUT; legal range 0..4.
- i_CLK  input  1  system clock; all state changes on the rising edge.
- i_RST_N  input  1  reset; asynchronous and active-low.
- i_VALID  input  1  operand pair valid.
- o_READY  output  1  controller can accept operands; high only in IDLE.
- i_MULTIPLICAND  input  W  operand A; drives the weights.
- i_MULTIPLIER  input  W  operand B; streamed serially.
- o_VALID  output  1  o_PRODUCT valid.
- i_READY  input  1  downstream accepts the product.
- o_PRODUCT  output  2W  unsigned A*B.
- o_ARRAY_WEIGHT  output  W  bit i goes to the weight input of cell i.
- o_ARRAY_IN  output  1  serial input to cell 0.
- o_ARRAY_CLR  output  1  synchronous clear of all array registers, active high.
- i_ARRAY_OUT  input  1  serial product bit from cell 0.

## Operation
- **States:**
  - IDLE: o_READY=1.
  - CLEAR: lasts 1 cycle, o_ARRAY_CLR=1.
  - RUN: lasts 2W+ARRAY_LAT cycles.
  - DONE: o_VALID=1.
- **Accept.** A handshake (i_VALID && o_READY) in IDLE latches A into the weight register and B into the feed shift register, zeroes the product register, and moves to CLEAR.
- **CLEAR to RUN.** CLEAR always moves to RUN and zeroes the RUN counter k.
- **Feed in RUN cycle k (k = 0..2W+ARRAY_LAT-1).**
  - o_ARRAY_IN = B[k] for k < W.
  - o_ARRAY_IN = 0 for k ≥ W.
- **Capture in RUN cycle k.** For k ≥ ARRAY_LAT, i_ARRAY_OUT is captured as product bit k-ARRAY_LAT. The product register shifts right with the new bit inserted at bit 2W-1, so after 2W captures bit 0 holds the first captured bit.
- **RUN to DONE.** In the last RUN cycle the controller moves to DONE.
- **DONE.** o_VALID=1 and o_PRODUCT is held stable. On the handshake (o_VALID && i_READY) the controller returns to IDLE.
- **Idle outputs.**
  - o_ARRAY_WEIGHT holds the last accepted A at all times; it is 0 after reset.
  - o_ARRAY_IN is 0 outside RUN.
- **Arithmetic.** Unsigned only. The product is exact in 2W bits; no overflow is possible.
- **Back-pressure.** If i_READY is low, the controller stays in DONE indefinitely. No new operands are accepted until the product is taken.
- **Input rules.** i_VALID outside IDLE is ignored; operands must be held by the source until accepted. i_MULTIPLICAND and i_MULTIPLIER changes after acceptance have no effect.

## Timing
- **Reset values.** Reset (i_RST_N low) takes effect immediately, regardless of clock:
  - State = IDLE.
  - o_READY=1.
  - o_VALID=0.
  - o_PRODUCT=0.
  - o_ARRAY_WEIGHT=0.
  - o_ARRAY_IN=0.
  - o_ARRAY_CLR=0.
- **Reset mid-operation.** A reset during CLEAR, RUN or DONE aborts the operation and discards the product. The next operation starts with CLEAR, so no array state leaks into it.
- **Latency.** With accept at cycle T:
  - CLEAR at T+1.
  - RUN at T+2 .. T+1+2W+ARRAY_LAT.
  - o_VALID first high at T+2+2W+ARRAY_LAT. For W=8, ARRAY_LAT=1 this is T+19.
- **Throughput.** The earliest next accept is the cycle after the output handshake, giving one product per 2W+ARRAY_LAT+3 cycles with i_READY held high.
- **Registered outputs.** All outputs are registered except o_READY, which is decoded from the state register.

## Configuration
- **Macro:** SYSTOLIC_MULT_CTRL_ZERO_SKIP_EN.
- **When defined:**
  - An accept with A==0 or B==0 goes directly from IDLE to DONE with o_PRODUCT=0.
  - o_VALID is high at T+1.
  - CLEAR and RUN are skipped, and o_ARRAY_CLR and o_ARRAY_IN stay 0.
  - o_ARRAY_WEIGHT still loads A.
- **When not defined:** zero operands take the full CLEAR/RUN sequence and yield 0 at T+2+2W+ARRAY_LAT.

## Test plan
- **Basic multiply.** W=8, ARRAY_LAT=1, behavioural array model; A=13, B=11, i_READY=1, accept at T.
  - o_ARRAY_CLR high at T+1 only.
  - o_ARRAY_IN follows 1,1,0,1,0,0,0,0 then zeros.
  - o_VALID at T+19 with o_PRODUCT=143.
  - Back in IDLE at T+20.
- **Full-scale operands.** A=255, B=255 gives o_PRODUCT=65025. A=1, B=128 gives 128. A=128, B=255 gives 32640.
- **Back-pressure.** A=200, B=3 with i_READY low for 10 cycles after o_VALID.
  - o_PRODUCT holds 600 and o_READY stays 0.
  - A second i_VALID pulse in this window is not accepted.
  - Raising i_READY gives o_READY=1 on the following cycle.
- **Reset mid-RUN.** Assert i_RST_N low at RUN cycle k=5.
  - All outputs take their reset values asynchronously.
  - After release, A=7, B=9 yields 63 with no corruption.
- **Zero operand, both builds.** A=0, B=200:
  - With SYSTOLIC_MULT_CTRL_ZERO_SKIP_EN: o_VALID at T+1, product 0, o_ARRAY_CLR never high.
  - Without it: o_VALID at T+19, product 0.
- **Latency parameter sweep.** ARRAY_LAT=0 and ARRAY_LAT=3 with W=4, A=15, B=15.
  - Product 225 in both cases.
  - o_VALID at T+10 and T+13 respectively.

Source files
------------

// File: rtl/systolic_mult_ctrl.sv
// systolic_mult_ctrl: sequencing controller for a W-cell bit-serial systolic
// multiplier array. It latches an operand pair, clears the array, then streams
// the multiplier LSB-first with zero padding. It also deserialises the 2W-bit
// product that cell 0 returns.
// Optional feature macro: SYSTOLIC_MULT_CTRL_ZERO_SKIP_EN. When it is defined,
// a zero operand short-circuits straight to DONE with a zero product.
module systolic_mult_ctrl #(
    parameter int unsigned W         = 8,
    parameter int unsigned ARRAY_LAT = 1
) (
    input  logic             i_CLK,
    input  logic             i_RST_N,
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic [W-1:0]     i_MULTIPLICAND,
    input  logic [W-1:0]     i_MULTIPLIER,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic [2*W-1:0]   o_PRODUCT,
    output logic [W-1:0]     o_ARRAY_WEIGHT,
    output logic             o_ARRAY_IN,
    output logic             o_ARRAY_CLR,
    input  logic             i_ARRAY_OUT
);

    localparam int unsigned RUN_LEN = 2 * W + ARRAY_LAT;
    localparam int unsigned KW      = $clog2(RUN_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [W-1:0]    weight;
    logic [W-1:0]    feed;
    logic [2*W-1:0]  product;
    logic [KW-1:0]   k;
    logic            array_in;
    logic            array_clr;
    logic            valid;
    logic            zero_op;
    logic            capture;

`ifdef SYSTOLIC_MULT_CTRL_ZERO_SKIP_EN
    assign zero_op = (i_MULTIPLICAND == '0) || (i_MULTIPLIER == '0);
`else
    assign zero_op = 1'b0;
`endif

    // Product bits only start arriving once the array latency has elapsed.
    if (ARRAY_LAT == 0) begin : g_cap_all
        assign capture = 1'b1;
    end else begin : g_cap_lat
        assign capture = (k >= KW'(ARRAY_LAT));
    end

    assign o_READY        = (state == IDLE);
    assign o_VALID        = valid;
    assign o_PRODUCT      = product;
    assign o_ARRAY_WEIGHT = weight;
    assign o_ARRAY_IN     = array_in;
    assign o_ARRAY_CLR    = array_clr;

    // Control FSM with registered array-side and result-side outputs.
    // o_ARRAY_IN is loaded one edge ahead, so RUN cycle k presents B[k].
    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state     <= IDLE;
            weight    <= '0;
            feed      <= '0;
            product   <= '0;
            k         <= '0;
            array_in  <= 1'b0;
            array_clr <= 1'b0;
            valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_VALID) begin
                        weight  <= i_MULTIPLICAND;
                        feed    <= i_MULTIPLIER;
                        product <= '0;
                        if (zero_op) begin
                            state <= DONE;
                            valid <= 1'b1;
                        end else begin
                            state     <= CLEAR;
                            array_clr <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    array_clr <= 1'b0;
                    k         <= '0;
                    array_in  <= feed[0];
                    feed      <= feed >> 1;
                    state     <= RUN;
                end
                RUN: begin
                    if (capture) begin
                        product <= {i_ARRAY_OUT, product[2*W-1:1]};
                    end
                    if (k == KW'(RUN_LEN - 1)) begin
                        state    <= DONE;
                        valid    <= 1'b1;
                        array_in <= 1'b0;
                    end else begin
                        k        <= k + KW'(1);
                        array_in <= feed[0];
                        feed     <= feed >> 1;
                    end
                end
                DONE: begin
                    if (i_READY) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mult_ctrl.sv
// Testbench for systolic_mult_ctrl. It drives three instances: W=8/LAT=1 as
// the main instance, plus W=4/LAT=0 and W=4/LAT=3. Each instance is connected
// to a behavioural bit-serial array model. Expected products are pushed to a
// scoreboard queue when an operation is accepted, and popped when the result
// appears. Zero-operand expectations follow SYSTOLIC_MULT_CTRL_ZERO_SKIP_EN.
module tb_systolic_mult_ctrl;

    logic clk;
    logic rst_n;

    // main instance (W=8, ARRAY_LAT=1)
    logic        valid, rdy_in, ready, ovalid, ain, clr, aout;
    logic [7:0]  mcand, mplier, weight;
    logic [15:0] product;

    // sweep instances (W=4): index 0 -> ARRAY_LAT=0, index 1 -> ARRAY_LAT=3
    logic       s_valid [2];
    logic       s_rdy   [2];
    logic       s_ready [2];
    logic       s_ovalid[2];
    logic       s_ain   [2];
    logic       s_clr   [2];
    logic       s_aout  [2];
    logic [3:0] s_mcand [2];
    logic [3:0] s_mplier[2];
    logic [3:0] s_weight[2];
    logic [7:0] s_product[2];

    logic [15:0] sb  [$];
    logic [7:0]  sbs [$];

    int n_cmp = 0;
    int n_err = 0;

    systolic_mult_ctrl #(.W(8), .ARRAY_LAT(1)) dut (
        .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(valid), .o_READY(ready),
        .i_MULTIPLICAND(mcand), .i_MULTIPLIER(mplier), .o_VALID(ovalid),
        .i_READY(rdy_in), .o_PRODUCT(product), .o_ARRAY_WEIGHT(weight),
        .o_ARRAY_IN(ain), .o_ARRAY_CLR(clr), .i_ARRAY_OUT(aout)
    );

    systolic_mult_ctrl #(.W(4), .ARRAY_LAT(0)) dut_l0 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(s_valid[0]), .o_READY(s_ready[0]),
        .i_MULTIPLICAND(s_mcand[0]), .i_MULTIPLIER(s_mplier[0]), .o_VALID(s_ovalid[0]),
        .i_READY(s_rdy[0]), .o_PRODUCT(s_product[0]), .o_ARRAY_WEIGHT(s_weight[0]),
        .o_ARRAY_IN(s_ain[0]), .o_ARRAY_CLR(s_clr[0]), .i_ARRAY_OUT(s_aout[0])
    );

    systolic_mult_ctrl #(.W(4), .ARRAY_LAT(3)) dut_l3 (
        .i_CLK(clk), .i_RST_N(rst_n), .i_VALID(s_valid[1]), .o_READY(s_ready[1]),
        .i_MULTIPLICAND(s_mcand[1]), .i_MULTIPLIER(s_mplier[1]), .o_VALID(s_ovalid[1]),
        .i_READY(s_rdy[1]), .o_PRODUCT(s_product[1]), .o_ARRAY_WEIGHT(s_weight[1]),
        .o_ARRAY_IN(s_ain[1]), .o_ARRAY_CLR(s_clr[1]), .i_ARRAY_OUT(s_aout[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural array: the n-th serial bit x adds x*A<<n to an accumulator.
    // Bit n of the accumulator is then final. It is returned ARRAY_LAT cycles later.
    function automatic logic [79:0] acc_step(input logic [79:0] s, input logic [31:0] w,
                                             input logic x, input int n);
        logic [79:0] t;
        t = '0;
        t[31:0] = w;
        return x ? (s + (t << n)) : s;
    endfunction

    logic [79:0] m_s [3] = '{default: '0};
    logic [4:0]  m_dl[3] = '{default: '0};
    int          m_n [3] = '{default: 0};

    // Array model for the main instance.
    always @(negedge clk) begin : model_main
        logic [79:0] s_nx;
        logic [4:0]  dl_nx;
        if (clr === 1'b1) begin
            s_nx = '0; dl_nx = '0; m_n[0] <= 0;
        end else begin
            s_nx  = acc_step(m_s[0], 32'(weight), ain, m_n[0]);
            dl_nx = {m_dl[0][3:0], s_nx[m_n[0]]};
            if (m_n[0] < 60) m_n[0] <= m_n[0] + 1;
        end
        m_s[0]  <= s_nx;
        m_dl[0] <= dl_nx;
        aout    <= dl_nx[1];
    end

    // Array model for the ARRAY_LAT=0 sweep instance.
    always @(negedge clk) begin : model_l0
        logic [79:0] s_nx;
        logic [4:0]  dl_nx;
        if (s_clr[0] === 1'b1) begin
            s_nx = '0; dl_nx = '0; m_n[1] <= 0;
        end else begin
            s_nx  = acc_step(m_s[1], 32'(s_weight[0]), s_ain[0], m_n[1]);
            dl_nx = {m_dl[1][3:0], s_nx[m_n[1]]};
            if (m_n[1] < 60) m_n[1] <= m_n[1] + 1;
        end
        m_s[1]    <= s_nx;
        m_dl[1]   <= dl_nx;
        s_aout[0] <= dl_nx[0];
    end

    // Array model for the ARRAY_LAT=3 sweep instance.
    always @(negedge clk) begin : model_l3
        logic [79:0] s_nx;
        logic [4:0]  dl_nx;
        if (s_clr[1] === 1'b1) begin
            s_nx = '0; dl_nx = '0; m_n[2] <= 0;
        end else begin
            s_nx  = acc_step(m_s[2], 32'(s_weight[1]), s_ain[1], m_n[2]);
            dl_nx = {m_dl[2][3:0], s_nx[m_n[2]]};
            if (m_n[2] < 60) m_n[2] <= m_n[2] + 1;
        end
        m_s[2]    <= s_nx;
        m_dl[2]   <= dl_nx;
        s_aout[1] <= dl_nx[3];
    end

    // One full operation on the main instance with i_READY high. Traces of
    // o_ARRAY_CLR / o_ARRAY_IN are indexed by cycle offset from the accept.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int exp_lat,
                          input string tag, output logic [63:0] clr_tr, output logic [63:0] ain_tr);
        int cyc;
        logic [15:0] exp_p;
        clr_tr = '0;
        ain_tr = '0;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL %s_ready_before: got %b want 1", tag, ready); end
        mcand = a; mplier = b; valid = 1'b1; rdy_in = 1'b1;
        sb.push_back({8'b0, a} * {8'b0, b});
        @(negedge clk);
        valid = 1'b0;
        cyc = 1;
        clr_tr[1] = clr;
        ain_tr[1] = ain;
        while (ovalid !== 1'b1 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            clr_tr[cyc] = clr;
            ain_tr[cyc] = ain;
        end
        n_cmp++;
        if (cyc != exp_lat) begin n_err++; $display("FAIL %s_latency: got %0d want %0d", tag, cyc, exp_lat); end
        exp_p = sb.pop_front();
        n_cmp++;
        if (product !== exp_p) begin n_err++; $display("FAIL %s_product: got %0d want %0d", tag, product, exp_p); end
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || ovalid !== 1'b0) begin
            n_err++; $display("FAIL %s_back_to_idle: ready=%b valid=%b want 1/0", tag, ready, ovalid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        valid = 1'b0; rdy_in = 1'b1; mcand = '0; mplier = '0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0; s_rdy[i] = 1'b1; s_mcand[i] = '0; s_mplier[i] = '0;
        end
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (ready !== 1'b1)    begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
        n_cmp++; if (ovalid !== 1'b0)   begin n_err++; $display("FAIL reset_valid: got %b want 0", ovalid); end
        n_cmp++; if (product !== 16'd0) begin n_err++; $display("FAIL reset_product: got %0d want 0", product); end
        n_cmp++; if (weight !== 8'd0)   begin n_err++; $display("FAIL reset_weight: got %0d want 0", weight); end
        n_cmp++; if (ain !== 1'b0)      begin n_err++; $display("FAIL reset_array_in: got %b want 0", ain); end
        n_cmp++; if (clr !== 1'b0)      begin n_err++; $display("FAIL reset_array_clr: got %b want 0", clr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [63:0] ct, at;
        run_op(8'd13, 8'd11, 19, "basic", ct, at);
        n_cmp++;
        if (ct !== 64'h2) begin n_err++; $display("FAIL basic_clr_trace: got %h want 2", ct); end
        n_cmp++;
        if (at !== 64'd44) begin n_err++; $display("FAIL basic_in_trace: got %h want 2c", at); end
        n_cmp++;
        if (weight !== 8'd13) begin n_err++; $display("FAIL basic_weight: got %0d want 13", weight); end
    endtask

    task automatic test_full_scale();
        logic [63:0] ct, at;
        run_op(8'd255, 8'd255, 19, "full_ff_ff", ct, at);
        run_op(8'd1,   8'd128, 19, "full_1_128", ct, at);
        run_op(8'd128, 8'd255, 19, "full_128_ff", ct, at);
    endtask

    task automatic test_back_pressure();
        int cyc;
        logic [15:0] exp_p;
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_before: got %b want 1", ready); end
        mcand = 8'd200; mplier = 8'd3; valid = 1'b1; rdy_in = 1'b0;
        sb.push_back(16'd200 * 16'd3);
        @(negedge clk);
        valid = 1'b0;
        cyc = 1;
        while (ovalid !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
        n_cmp++;
        if (cyc != 19) begin n_err++; $display("FAIL bp_latency: got %0d want 19", cyc); end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (product !== sb[0] || ready !== 1'b0 || ovalid !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold_%0d: product=%0d ready=%b valid=%b want %0d/0/1", i, product, ready, ovalid, sb[0]);
            end
            if (i == 3) begin mcand = 8'd5; mplier = 8'd5; valid = 1'b1; end
            if (i == 4) valid = 1'b0;
            @(negedge clk);
        end
        rdy_in = 1'b1;
        exp_p = sb.pop_front();
        n_cmp++;
        if (product !== exp_p) begin n_err++; $display("FAIL bp_product: got %0d want %0d", product, exp_p); end
        @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || ovalid !== 1'b0) begin
            n_err++; $display("FAIL bp_release: ready=%b valid=%b want 1/0", ready, ovalid);
        end
        n_cmp++;
        if (weight !== 8'd200) begin n_err++; $display("FAIL bp_no_accept: weight %0d want 200", weight); end
    endtask

    task automatic test_reset_mid_run();
        logic [63:0] ct, at;
        @(negedge clk);
        mcand = 8'd50; mplier = 8'd77; valid = 1'b1; rdy_in = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        repeat (6) @(negedge clk);
        // now in RUN cycle k=5
        n_cmp++;
        if (ready !== 1'b0 || weight !== 8'd50) begin
            n_err++; $display("FAIL rst_run_precond: ready=%b weight=%0d want 0/50", ready, weight);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (ready !== 1'b1)    begin n_err++; $display("FAIL rst_run_ready: got %b want 1", ready); end
        n_cmp++; if (ovalid !== 1'b0)   begin n_err++; $display("FAIL rst_run_valid: got %b want 0", ovalid); end
        n_cmp++; if (product !== 16'd0) begin n_err++; $display("FAIL rst_run_product: got %0d want 0", product); end
        n_cmp++; if (weight !== 8'd0)   begin n_err++; $display("FAIL rst_run_weight: got %0d want 0", weight); end
        n_cmp++; if (ain !== 1'b0 || clr !== 1'b0) begin
            n_err++; $display("FAIL rst_run_array: in=%b clr=%b want 0/0", ain, clr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd7, 8'd9, 19, "rst_run_after", ct, at);
    endtask

    task automatic test_zero_operand();
        logic [63:0] ct, at;
`ifdef SYSTOLIC_MULT_CTRL_ZERO_SKIP_EN
        run_op(8'd0, 8'd200, 1, "zero_skip", ct, at);
        n_cmp++;
        if (ct !== 64'h0 || at !== 64'h0) begin
            n_err++; $display("FAIL zero_skip_array: clr_trace=%h in_trace=%h want 0/0", ct, at);
        end
`else
        run_op(8'd0, 8'd200, 19, "zero_full", ct, at);
        n_cmp++;
        if (ct !== 64'h2) begin n_err++; $display("FAIL zero_full_clr_trace: got %h want 2", ct); end
`endif
        n_cmp++;
        if (weight !== 8'd0) begin n_err++; $display("FAIL zero_weight: got %0d want 0", weight); end
    endtask

    task automatic run_small(input int idx, input int exp_lat);
        int cyc;
        logic [7:0] exp_p;
        @(negedge clk);
        n_cmp++;
        if (s_ready[idx] !== 1'b1) begin n_err++; $display("FAIL sweep%0d_ready: got %b want 1", idx, s_ready[idx]); end
        s_mcand[idx] = 4'd15; s_mplier[idx] = 4'd15; s_valid[idx] = 1'b1; s_rdy[idx] = 1'b1;
        sbs.push_back(8'd15 * 8'd15);
        @(negedge clk);
        s_valid[idx] = 1'b0;
        cyc = 1;
        while (s_ovalid[idx] !== 1'b1 && cyc < 60) begin @(negedge clk); cyc++; end
        n_cmp++;
        if (cyc != exp_lat) begin n_err++; $display("FAIL sweep%0d_latency: got %0d want %0d", idx, cyc, exp_lat); end
        exp_p = sbs.pop_front();
        n_cmp++;
        if (s_product[idx] !== exp_p) begin
            n_err++; $display("FAIL sweep%0d_product: got %0d want %0d", idx, s_product[idx], exp_p);
        end
        @(negedge clk);
    endtask

    task automatic test_lat_sweep();
        run_small(0, 10);
        run_small(1, 13);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_scale();
        test_back_pressure();
        test_reset_mid_run();
        test_zero_operand();
        test_lat_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
